sisc_fetch: RTL and testbench

- Instruction-fetch and branch unit for the SISC computer.
- Holds the PC and IR and runs the instruction-memory read handshake.
- Decodes IR fields and feeds opcode/mm to the control FSM.
- Resolves branches from the status flags when the control FSM strobes execute. It is the producer side of the control FSM's opcode/mm/stat inputs.

---
 rtl/sisc_pkg.sv | 37 +++
 rtl/sisc_br_resolve.sv | 44 ++++
 rtl/sisc_fetch.sv | 148 ++++++++++++++
 tb/tb_sisc_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// SISC shared definitions: opcode and addressing-mode constants, IR field
// bit positions and the fetch FSM state encoding.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam logic [3:0] am_imm = 4'd8;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;
  localparam int RD_MSB  = 23;
  localparam int RD_LSB  = 20;
  localparam int RS_MSB  = 19;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 12;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sisc_br_resolve.sv
// Combinational branch resolution: decides taken/target from the current IR
// fields, status flags and the (already incremented) PC.
module sisc_br_resolve
  import sisc_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [3:0]        opcode,
  input  logic [3:0]        mm,
  input  logic [3:0]        stat,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);

  logic              hit;
  logic [ADDR_W-1:0] imm_abs;
  logic [ADDR_W-1:0] imm_rel;

  assign hit = |(mm & stat);

  // Absolute targets are zero-extended, relative offsets sign-extended.
  if (ADDR_W > 16) begin : g_wide
    assign imm_abs = {{(ADDR_W-16){1'b0}}, imm};
    assign imm_rel = {{(ADDR_W-16){imm[15]}}, imm};
  end else begin : g_narrow
    assign imm_abs = imm[ADDR_W-1:0];
    assign imm_rel = imm[ADDR_W-1:0];
  end

  always_comb begin
    taken  = 1'b0;
    target = pc;
    case (opcode)
      BRA: begin taken = hit;  target = imm_abs;      end
      BRR: begin taken = hit;  target = pc + imm_rel; end
      BNE: begin taken = !hit; target = imm_abs;      end
      BNR: begin taken = !hit; target = pc + imm_rel; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch/branch unit: PC, IR, imem read handshake and branch
// update. Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int                TIMEOUT  = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_req,
  input  logic              br_eval,
  input  logic [3:0]        stat,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              ir_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [3:0]        rd_sel,
  output logic [3:0]        rs_sel,
  output logic [3:0]        rt_sel,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic              fetch_err
`endif
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       ir_reg, ir_next;
  logic              ir_valid_reg, ir_valid_next;
  logic              halted_reg, halted_next;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              start_fetch;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             fetch_err_reg, fetch_err_next;
`endif

  assign opcode    = ir_reg[OPC_MSB:OPC_LSB];
  assign mm        = ir_reg[MM_MSB:MM_LSB];
  assign rd_sel    = ir_reg[RD_MSB:RD_LSB];
  assign rs_sel    = ir_reg[RS_MSB:RS_LSB];
  assign rt_sel    = ir_reg[RT_MSB:RT_LSB];
  assign imm       = ir_reg[IMM_MSB:IMM_LSB];
  assign pc        = pc_reg;
  assign ir_valid  = ir_valid_reg;
  assign halted    = halted_reg;
  assign imem_rd   = (state_reg == ST_REQ);
  assign imem_addr = pc_reg;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_reg;
`endif

  sisc_br_resolve #(.ADDR_W(ADDR_W)) u_br_resolve (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .pc     (pc_reg),
    .imm    (imm),
    .taken  (br_taken),
    .target (br_target)
  );

  assign start_fetch = fetch_req && !halted_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_valid_next = ir_valid_reg;
    halted_next   = halted_reg;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
    fetch_err_next = fetch_err_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        // Branch update lands first so a same-cycle fetch uses the new PC.
        if (state_reg == ST_HOLD && br_eval && br_taken) pc_next = br_target;
        if (start_fetch) begin
          state_next    = ST_REQ;
          ir_valid_next = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_next = '0;
`endif
        end
      end
      ST_REQ: begin
        if (imem_valid) begin
          ir_next       = imem_rdata;
          pc_next       = pc_reg + 1'b1;
          ir_valid_next = 1'b1;
          state_next    = ST_HOLD;
          if (imem_rdata[OPC_MSB:OPC_LSB] == HLT) halted_next = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          ir_next        = '0;
          ir_valid_next  = 1'b1;
          fetch_err_next = 1'b1;
          state_next     = ST_HOLD;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      halted_reg   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_reg  <= '0;
      fetch_err_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_valid_reg <= ir_valid_next;
      halted_reg   <= halted_next;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
      fetch_err_reg <= fetch_err_next;
`endif
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch: directed scenarios plus randomized
// fetch/branch traffic against a transaction-level PC/IR model.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        fetch_req = 1'b0;
  logic        br_eval = 1'b0;
  logic [3:0]  stat = 4'h0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic        ir_valid;
  logic [3:0]  opcode, mm, rd_sel, rs_sel, rt_sel;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        halted;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] m_pc;

  always #5 clk = ~clk;

  sisc_fetch dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .fetch_req  (fetch_req),
    .br_eval    (br_eval),
    .stat       (stat),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .ir_valid   (ir_valid),
    .opcode     (opcode),
    .mm         (mm),
    .rd_sel     (rd_sel),
    .rs_sel     (rs_sel),
    .rt_sel     (rt_sel),
    .imm        (imm),
    .pc         (pc),
    .halted     (halted)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_err  (fetch_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_f = 1'b0; fetch_req = 1'b0; br_eval = 1'b0; imem_valid = 1'b0;
    tick();
    rst_f = 1'b1;
    m_pc = 16'h0;
  endtask

  // Pulse fetch_req, let memory answer after 'delay' wait cycles; reports
  // how many cycles imem_rd was seen high and the first address presented.
  task automatic drive_fetch(input logic [31:0] word, input int delay, input bit noise,
                             output int rd_cycles, output logic [15:0] addr_seen);
    rd_cycles = 0;
    addr_seen = 16'hxxxx;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      if (imem_rd) begin
        if (rd_cycles == 0) addr_seen = imem_addr;
        rd_cycles++;
      end
      if (noise) begin
        br_eval = 1'($urandom); fetch_req = 1'($urandom); stat = 4'($urandom);
      end
      if (i == delay) begin
        imem_valid = 1'b1; imem_rdata = word;
      end
      tick();
      imem_valid = 1'b0; imem_rdata = $urandom; br_eval = 1'b0; fetch_req = 1'b0;
    end
  endtask

  task automatic do_branch(input logic [3:0] s);
    stat = s; br_eval = 1'b1;
    tick();
    br_eval = 1'b0;
  endtask

  function automatic logic [15:0] model_branch(logic [31:0] ir, logic [15:0] cur, logic [3:0] s);
    int  op  = int'(ir[31:28]);
    bit  any = (ir[27:24] & s) != 4'h0;
    int  off = int'($signed(ir[15:0]));
    logic [15:0] rel = 16'((int'(cur) + off) % 65536);
    case (op)
      4: return any  ? ir[15:0] : cur;
      5: return any  ? rel      : cur;
      6: return !any ? ir[15:0] : cur;
      7: return !any ? rel      : cur;
      default: return cur;
    endcase
  endfunction

  task automatic test_reset;
    rst_f = 1'b0; fetch_req = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hF123_4567;
    tick();
    fetch_req = 1'b0; imem_valid = 1'b0;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_imem_rd got=%b exp=0", imem_rd); end
    checks++; if (pc !== 16'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if ({opcode, mm, imm} !== 24'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0", {opcode, mm, imm}); end
    rst_f = 1'b1; m_pc = 16'h0;
    $display("txn reset done");
  endtask

  task automatic test_basic_fetch;
    int rdc; logic [15:0] a;
    do_reset();
    drive_fetch(32'h1200_0005, 1, 1'b0, rdc, a);
    checks++; if (rdc !== 2) begin errors++; $display("FAIL basic_rd_cycles got=%0d exp=2", rdc); end
    checks++; if (a !== 16'h0) begin errors++; $display("FAIL basic_addr got=%h exp=0000", a); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_ir_valid got=%b exp=1", ir_valid); end
    checks++; if ({opcode, mm, imm} !== 24'h12_0005) begin errors++; $display("FAIL basic_fields got=%h exp=120005", {opcode, mm, imm}); end
    checks++; if (pc !== 16'h1) begin errors++; $display("FAIL basic_pc got=%h exp=0001", pc); end
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL basic_rd_drop got=%b exp=0", imem_rd); end
    $display("txn basic fetch pc=%h opcode=%h", pc, opcode);
  endtask

  task automatic test_branches;
    int rdc; logic [15:0] a;
    do_reset();
    drive_fetch(32'h4100_0020, 0, 1'b0, rdc, a);
    do_branch(4'b0000);
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL bra_not_taken got=%h exp=0001", pc); end
    do_branch(4'b0001);
    checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL bra_taken got=%h exp=0020", pc); end
    do_reset();
    drive_fetch(32'h0, 0, 1'b0, rdc, a);
    drive_fetch(32'h0, 2, 1'b0, rdc, a);
    drive_fetch(32'h7800_FFFE, 0, 1'b0, rdc, a);
    checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL bnr_pre got=%h exp=0003", pc); end
    do_branch(4'b0000);
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL bnr_taken got=%h exp=0001", pc); end
    do_reset();
    drive_fetch(32'h4100_FFFE, 0, 1'b0, rdc, a);
    do_branch(4'b0001);
    drive_fetch(32'h5100_0002, 0, 1'b0, rdc, a);
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL brr_pre got=%h exp=ffff", pc); end
    do_branch(4'b1001);
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL brr_wrap got=%h exp=0001", pc); end
    $display("txn directed branches pc=%h", pc);
  endtask

  task automatic test_same_cycle;
    int rdc; logic [15:0] a;
    do_reset();
    drive_fetch(32'h4100_0040, 0, 1'b0, rdc, a);
    stat = 4'b0001; br_eval = 1'b1; fetch_req = 1'b1;
    tick();
    br_eval = 1'b0; fetch_req = 1'b0;
    checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL same_rd got=%b exp=1", imem_rd); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL same_addr got=%h exp=0040", imem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL same_ir_valid got=%b exp=0", ir_valid); end
    checks++; if (opcode !== 4'h4) begin errors++; $display("FAIL same_old_ir got=%h exp=4", opcode); end
    imem_valid = 1'b1; imem_rdata = 32'h4100_0080;
    tick();
    imem_valid = 1'b0;
    checks++; if (pc !== 16'h0041) begin errors++; $display("FAIL same_pc got=%h exp=0041", pc); end
    // Branch strobe while the next fetch is outstanding must not move the PC.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; br_eval = 1'b1; stat = 4'b0001;
    tick();
    br_eval = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_valid = 1'b0;
    checks++; if (pc !== 16'h0042) begin errors++; $display("FAIL br_in_req got=%h exp=0042", pc); end
    $display("txn same-cycle branch+fetch pc=%h", pc);
  endtask

  task automatic test_halt;
    int rdc; logic [15:0] a;
    do_reset();
    drive_fetch(32'hF000_0000, 0, 1'b0, rdc, a);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", halted); end
    fetch_req = 1'b1;
    tick();
    tick();
    fetch_req = 1'b0;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL halt_no_fetch got=%b exp=0", imem_rd); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got=%b exp=1", halted); end
    $display("txn halt halted=%b", halted);
  endtask

  task automatic test_reset_mid_req;
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL midreq_rd got=%b exp=1", imem_rd); end
    rst_f = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    checks++; if ({imem_rd, ir_valid} !== 2'b00) begin errors++; $display("FAIL midreq_flags got=%b exp=00", {imem_rd, ir_valid}); end
    checks++; if (pc !== 16'h0) begin errors++; $display("FAIL midreq_pc got=%h exp=0000", pc); end
    rst_f = 1'b1;
    tick();
    imem_valid = 1'b0;
    checks++; if ({ir_valid, opcode, pc} !== 21'h0) begin errors++; $display("FAIL late_valid got=%h exp=0", {ir_valid, opcode, pc}); end
    $display("txn reset mid-request");
  endtask

  task automatic test_random;
    int rdc; int dly; logic [15:0] a; logic [31:0] w; logic [3:0] s;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      w[31:28] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(4, 7)) : 4'($urandom_range(0, 14));
      dly = $urandom_range(0, 3);
      drive_fetch(w, dly, 1'b1, rdc, a);
      checks++; if (rdc !== dly + 1) begin errors++; $display("FAIL rnd_rd_cycles n=%0d got=%0d exp=%0d", n, rdc, dly + 1); end
      checks++; if (a !== m_pc) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, a, m_pc); end
      checks++; if ({ir_valid, opcode, mm, rd_sel, rs_sel, rt_sel, imm} !== {1'b1, w[31:12], w[15:0]})
        begin errors++; $display("FAIL rnd_fields n=%0d got=%h exp=%h", n,
          {ir_valid, opcode, mm, rd_sel, rs_sel, rt_sel, imm}, {1'b1, w[31:12], w[15:0]}); end
      m_pc = m_pc + 16'd1;
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc_inc n=%0d got=%h exp=%h", n, pc, m_pc); end
      if ($urandom_range(0, 2) != 0) begin
        s = 4'($urandom);
        m_pc = model_branch(w, m_pc, s);
        do_branch(s);
        checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_branch n=%0d ir=%h stat=%b got=%h exp=%h", n, w, s, pc, m_pc); end
      end
      $display("txn %0d word=%h delay=%0d pc=%h", n, w, dly, pc);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout;
    int rdc; logic [15:0] a;
    do_reset();
    drive_fetch(32'h1000_0000, 0, 1'b0, rdc, a);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    checks++; if ({imem_rd, fetch_err} !== 2'b10) begin errors++; $display("FAIL tmo_early got=%b exp=10", {imem_rd, fetch_err}); end
    tick();
    checks++; if ({fetch_err, ir_valid, imem_rd} !== 3'b110) begin errors++; $display("FAIL tmo_flags got=%b exp=110", {fetch_err, ir_valid, imem_rd}); end
    checks++; if ({opcode, pc} !== {4'h0, 16'h0001}) begin errors++; $display("FAIL tmo_state got=%h exp=00001", {opcode, pc}); end
    $display("txn timeout fetch_err=%b", fetch_err);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fetch();
    test_branches();
    test_same_cycle();
    test_halt();
    test_reset_mid_req();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
